nibble_to_word_packer: RTL and testbench

NIBBLE_TO_WORD_PACKER -- requirements
Module: nibble_to_word_packer

---
 rtl/nibble_to_word_packer_pkg.sv | 20 ++
 rtl/nibble_to_word_packer_counter.sv | 32 +++
 rtl/nibble_to_word_packer.sv | 132 +++++++++++++
 tb/tb_nibble_to_word_packer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_to_word_packer_pkg.sv
// Shared widths and state encoding for the nibble-to-word packer.
// The FSM state type is a plain 2-bit vector so the encoding is fixed by the localparams below.
package nibble_to_word_packer_pkg;

    localparam int NIB_W  = 4;
    localparam int WORD_W = 16;
    localparam int NIBS   = WORD_W / NIB_W;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t COLLECT = 2'd1;
    localparam state_t LOAD    = 2'd2;

    // Width of a counter that indexes n positions; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_to_word_packer_counter.sv
// nibble_counter: modulo-NIBS position counter with synchronous clear and increment.
// tc flags the last nibble position of a word, so the increment that leaves it wraps to 0.
module nibble_counter
#(
    parameter int NIBS  = nibble_to_word_packer_pkg::NIBS,
    parameter int CNT_W = nibble_to_word_packer_pkg::cnt_width(NIBS)
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBS - 1);

    assign tc = (cnt == LAST);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/nibble_to_word_packer.sv
// Packs four nibbles (first = most significant) into a 16-bit word and strobes ld for one cycle.
// The FSM is Moore: in_ready and ld depend on the state alone.
module nibble_to_word_packer
    import nibble_to_word_packer_pkg::state_t,
           nibble_to_word_packer_pkg::IDLE,
           nibble_to_word_packer_pkg::COLLECT,
           nibble_to_word_packer_pkg::LOAD,
           nibble_to_word_packer_pkg::cnt_width;
#(
    parameter int NIB_W  = nibble_to_word_packer_pkg::NIB_W,
    parameter int WORD_W = nibble_to_word_packer_pkg::WORD_W
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [NIB_W-1:0]  in_data,
    input  logic              flush,
    output logic              in_ready,
    output logic              ld,
    output logic [WORD_W-1:0] out,
    output logic [7:0]        word_cnt
);

    localparam int NWORD = WORD_W / NIB_W;
    localparam int CNT_W = cnt_width(NWORD);

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] shift_q;
    logic [CNT_W-1:0]  nib_cnt;
    logic              nib_tc;
    logic              accept;
    logic              take;
    logic              abort;
    logic              last_nib;

    // flush only aborts assembly; in LOAD the finished word is already committed.
    assign accept   = in_valid & in_ready;
    assign abort    = flush & (state != LOAD);
    assign take     = accept & ~flush;
    assign last_nib = take & (state == COLLECT) & nib_tc;

    nibble_counter #(
        .NIBS  (NWORD),
        .CNT_W (CNT_W)
    ) u_nib_cnt (
        .clk (clk),
        .rst (rst),
        .clr (abort),
        .inc (take),
        .cnt (nib_cnt),
        .tc  (nib_tc)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (abort)     state_nxt = IDLE;
                else if (take) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (abort)         state_nxt = IDLE;
                else if (last_nib) state_nxt = LOAD;
            end
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: output decode ----------------
    always_comb begin
        in_ready = 1'b1;
        ld       = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b0;
                ld       = 1'b1;
            end
            default: begin
                in_ready = 1'b1;
                ld       = 1'b0;
            end
        endcase
    end

    // ---------------- datapath ----------------
    // The first nibble of a word starts from a cleared register so no stale bits linger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
        end else if (abort) begin
            shift_q <= '0;
        end else if (take) begin
            if (state == IDLE) begin
                shift_q <= {{(WORD_W-NIB_W){1'b0}}, in_data};
            end else begin
                shift_q <= {shift_q[WORD_W-NIB_W-1:0], in_data};
            end
        end
    end

    // out is written only with a complete word, on the edge that enters LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else if (last_nib) begin
            out <= {shift_q[WORD_W-NIB_W-1:0], in_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= 8'd0;
        end else if (state == LOAD) begin
            word_cnt <= word_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_nibble_to_word_packer.sv
// Randomised self-checking bench for nibble_to_word_packer against a queue-based word model.
// Outputs are sampled on the falling edge; the model advances on each rising edge.
module tb_nibble_to_word_packer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        flush;
    logic        in_ready;
    logic        ld;
    logic [15:0] out_w;
    logic [7:0]  word_cnt;

    int errors = 0;
    int checks = 0;

    nibble_to_word_packer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .flush    (flush),
        .in_ready (in_ready),
        .ld       (ld),
        .out      (out_w),
        .word_cnt (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int unsigned m_nibs[$];
    bit          m_load;
    int unsigned m_out;
    int unsigned m_wcnt;
    bit          m_acc;

    // Observed words and strobe count, recorded from the DUT at each sample point.
    logic [15:0] words[$];
    int          ld_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_nibs.delete();
        m_load = 0;
        m_out  = 0;
        m_wcnt = 0;
        m_acc  = 0;
    endtask

    // One rising edge: a finished word occupies one cycle, during which nothing is taken.
    task automatic model_edge(input bit v, input int unsigned d, input bit f);
        m_acc = 0;
        if (m_load) begin
            m_load = 0;
            m_wcnt = (m_wcnt + 1) % 256;
        end else if (f) begin
            m_nibs.delete();
        end else if (v) begin
            m_acc = 1;
            m_nibs.push_back(d);
            if (m_nibs.size() == 4) begin
                m_out  = m_nibs[0] * 4096 + m_nibs[1] * 256 + m_nibs[2] * 16 + m_nibs[3];
                m_load = 1;
                m_nibs.delete();
            end
        end
    endtask

    task automatic step(input bit v, input logic [3:0] d, input bit f);
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(!m_load));
        check("ld", 32'(ld), 32'(m_load));
        check("out", 32'(out_w), m_out);
        check("word_cnt", 32'(word_cnt), m_wcnt);
        if (ld === 1'b1) begin
            ld_seen++;
            words.push_back(out_w);
        end
        in_valid = v;
        in_data  = d;
        flush    = f;
        @(posedge clk);
        model_edge(v, 32'(d), f);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        check("rst_ld", 32'(ld), 32'd0);
        check("rst_out", 32'(out_w), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] nib8[8];
        int         idx;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'h0;
        flush    = 1'b0;
        ld_seen  = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Back-to-back A,B,C,D.
        do_reset();
        words.delete();
        step(1'b1, 4'hA, 1'b0);
        step(1'b1, 4'hB, 1'b0);
        step(1'b1, 4'hC, 1'b0);
        step(1'b1, 4'hD, 1'b0);
        idle(2);
        check("abcd_words", 32'(words.size()), 32'd1);
        if (words.size() > 0) check("abcd_value", 32'(words[0]), 32'hABCD);
        @(negedge clk);
        check("abcd_word_cnt", 32'(word_cnt), 32'd1);

        // 1,2,3,4 with random idle gaps of 0-3 cycles.
        words.delete();
        ld_seen = 0;
        for (int i = 1; i <= 4; i++) begin
            idle($urandom_range(0, 3));
            step(1'b1, 4'(i), 1'b0);
        end
        idle(2);
        check("gap_ld_pulses", 32'(ld_seen), 32'd1);
        if (words.size() > 0) check("gap_value", 32'(words[0]), 32'h1234);

        // 5,6 then flush, then valid+flush dropped, then 1,2,3,4.
        words.delete();
        step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'h6, 1'b0);
        step(1'b0, 4'h0, 1'b1);
        step(1'b1, 4'h7, 1'b1);
        step(1'b1, 4'h1, 1'b0);
        step(1'b1, 4'h2, 1'b0);
        step(1'b1, 4'h3, 1'b0);
        step(1'b1, 4'h4, 1'b0);
        idle(2);
        check("flush_words", 32'(words.size()), 32'd1);
        if (words.size() > 0) check("flush_value", 32'(words[0]), 32'h1234);

        // Flush arriving during LOAD must not suppress the strobe.
        words.delete();
        step(1'b1, 4'h9, 1'b0);
        step(1'b1, 4'h8, 1'b0);
        step(1'b1, 4'h7, 1'b0);
        step(1'b1, 4'h6, 1'b0);
        step(1'b1, 4'h5, 1'b1);
        idle(2);
        check("load_flush_words", 32'(words.size()), 32'd1);
        if (words.size() > 0) check("load_flush_value", 32'(words[0]), 32'h9876);

        // in_valid held high through LOAD: 8 nibbles, two words in 10 cycles.
        words.delete();
        for (int i = 0; i < 8; i++) nib8[i] = 4'($urandom_range(0, 15));
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, nib8[idx % 8], 1'b0);
            if (m_acc) idx++;
        end
        idle(1);
        check("held_words", 32'(words.size()), 32'd2);
        if (words.size() == 2) begin
            check("held_word0", 32'(words[0]), 32'({nib8[0], nib8[1], nib8[2], nib8[3]}));
            check("held_word1", 32'(words[1]), 32'({nib8[4], nib8[5], nib8[6], nib8[7]}));
        end

        // Reset after two nibbles, then a clean word.
        words.delete();
        step(1'b1, 4'hE, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        do_reset();
        step(1'b1, 4'h3, 1'b0);
        step(1'b1, 4'hC, 1'b0);
        step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'hA, 1'b0);
        idle(2);
        check("post_rst_words", 32'(words.size()), 32'd1);
        if (words.size() > 0) check("post_rst_value", 32'(words[0]), 32'h3C5A);

        // 256 words wrap word_cnt to 0; the 257th gives 1.
        do_reset();
        ld_seen = 0;
        for (int c = 0; c < 256 * 5; c++) step(1'b1, 4'($urandom_range(0, 15)), 1'b0);
        idle(1);
        check("wrap_ld_pulses", 32'(ld_seen), 32'd256);
        @(negedge clk);
        check("wrap_word_cnt", 32'(word_cnt), 32'd0);
        for (int c = 0; c < 5; c++) step(1'b1, 4'($urandom_range(0, 15)), 1'b0);
        idle(1);
        @(negedge clk);
        check("wrap_plus1_word_cnt", 32'(word_cnt), 32'd1);

        // Random valid/flush traffic against the model.
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 15) == 0));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
